// File: rtl/rsa_crypt.sv
// Modular exponentiation base^exponent mod n using left-to-right square-and-multiply.
// Each modular multiply is an interleaved shift-add, one exponent-independent step per cycle.
module rsa_crypt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             finish
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] base_q, exp_q, n_q, r;
    logic [WIDTH:0]   acc;
    logic [IW-1:0]    idx, cnt;

    logic [WIDTH-1:0] mul_a;
    logic             mul_bit;
    logic [WIDTH:0]   n_ext, dbl, red1, sum, acc_next;

    // The multiplier operand scanned bit by bit is r in both phases:
    // SQR forms r*r, MUL forms base*r.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        mul_a    = (state == MUL) ? base_q : r;
        mul_bit  = r[cnt];
        n_ext    = {1'b0, n_q};
        dbl      = {acc[WIDTH-1:0], 1'b0};
        red1     = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum      = mul_bit ? red1 + {1'b0, mul_a} : red1;
        acc_next = (sum >= n_ext) ? sum - n_ext : sum;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_q <= '0;
            exp_q  <= '0;
            n_q    <= '0;
            r      <= '0;
            acc    <= '0;
            idx    <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            finish <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exponent;
                        n_q    <= n;
                        r      <= WIDTH'(1);
                        acc    <= '0;
                        idx    <= LAST;
                        cnt    <= LAST;
                        busy   <= 1'b1;
                        if (n < WIDTH'(2)) begin
                            result <= '0;
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= SQR;
                        end
                    end
                end
                SQR, MUL: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        acc <= '0;
                        cnt <= LAST;
                        r   <= acc_next[WIDTH-1:0];
                        if (state == SQR && exp_q[idx]) begin
                            state <= MUL;
                        end else if (idx == '0) begin
                            result <= acc_next[WIDTH-1:0];
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SQR;
                        end
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rsa_crypt.md
RSA_CRYPT -- requirements
Module: rsa_crypt

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand width of base, exponent, modulus and result in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request pulse, sampled on rising clk.
REQ-005 SHALL have port: base  input  WIDTH  message or ciphertext, precondition base < n.
REQ-006 SHALL have port: exponent  input  WIDTH  public key e or private key d, zero-extended by the caller.
REQ-007 SHALL have port: n  input  WIDTH  modulus p*q.
REQ-008 SHALL have port: result  output  WIDTH  base^exponent mod n.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: finish  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL compute result = base^exponent mod n by left-to-right square-and-multiply over all WIDTH exponent bits, MSB first, with no leading-zero skip.
REQ-012 SHALL implement every modular multiply a*b mod n as interleaved shift-add: acc=0; for i = WIDTH-1 downto 0: acc = 2*acc mod n, then if b[i], acc = acc + a mod n; one step per cycle, WIDTH cycles per multiply.
REQ-013 SHALL hold intermediates in WIDTH+1 bits and reduce each step by at most one conditional subtract of n; no divider.
REQ-014 SHALL implement states IDLE, SQR, MUL and DONE.
REQ-015 SHALL, in IDLE with start=1 at edge T0, latch base, exponent and n, set r=1, set bit index=WIDTH-1 and go to SQR; later input changes SHALL have no effect.
REQ-016 SHALL make SQR compute r=r*r mod n over WIDTH cycles; on the last step go to MUL if exponent[idx]=1, else go to DONE if idx=0, else decrement idx and stay in SQR.
REQ-017 SHALL make MUL compute r=r*base mod n over WIDTH cycles; on the last step go to DONE if idx=0, else decrement idx and go to SQR.
REQ-018 SHALL make DONE drive finish=1 for exactly one cycle and go to IDLE.
REQ-019 SHALL hold result from DONE until the next accepted start.
REQ-020 SHALL give latency, with w = popcount(exponent): finish high in the cycle following edge T0 + WIDTH*(WIDTH+w).
REQ-021 SHALL keep this data-dependent latency: it is the intended timing side channel and SHALL NOT be equalised.
REQ-022 SHALL ignore start when the state is SQR, MUL or DONE.
REQ-023 SHALL handle n < 2 by going from IDLE directly to DONE at T0 with result=0; finish high in the cycle after T0.
REQ-024 SHALL produce result=1 in 16*16 cycles for exponent=0 with n >= 2.
REQ-025 SHALL leave behaviour unspecified for base >= n; the bench SHALL NOT drive it.

Reset
REQ-026 SHALL, with rst_n=0 at any time, including mid-operation, immediately force state=IDLE, result=0, busy=0, finish=0 and clear all internal registers.
REQ-027 SHALL accept start on the first rising edge with rst_n=1; no operation SHALL resume after reset.

Verification
REQ-028 SHALL cover encrypt: n=3127, exponent=3, base=65, start at T0 -> result=2576, finish in the cycle after T0+288.
REQ-029 SHALL cover decrypt: n=3127, exponent=2011, base=2576 -> result=65, finish in the cycle after T0+400.
REQ-030 SHALL cover exponent=0, n=3127, base=1234 -> result=1 after T0+256; exponent=1 -> result=1234 after T0+272.
REQ-031 SHALL cover a second start pulse during SQR plus base/n changes mid-run -> ignored; result of the first job unchanged; exactly one finish pulse.
REQ-032 SHALL cover rst_n low for 1 cycle at T0+100 of a decrypt -> busy=0, result=0, no finish; a fresh start then gives the correct result with full latency.
REQ-033 SHALL cover n=1, base=0, exponent=5 -> result=0, finish in the cycle after T0.
